// File: rtl/eth_mdio_ctrl.sv
// Clause-22 MDIO management master: one PHY register read or write per accepted request.
// MDC is divided down from clk; MDIO is split into o/oe/i for a tristate built at the top level.
module eth_mdio_ctrl #(
  parameter int         MDC_HALF    = 25,
  parameter logic [4:0] PHY_ADDR    = 5'h01,
  parameter bit         PREAMBLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int            CW        = $clog2(2 * MDC_HALF);
  localparam logic [CW-1:0] LAST_LOW  = CW'(MDC_HALF - 1);
  localparam logic [CW-1:0] LAST_HIGH = CW'(2 * MDC_HALF - 1);

  generate
    if (MDC_HALF < 4) begin : g_bad_mdc_half
      $error("eth_mdio_ctrl: MDC_HALF must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_bits;
  logic [31:0]   r_tx;
  logic [15:0]   r_rx;
  logic          r_write;
  logic          r_ta_err;
  logic [1:0]    r_sync;
  logic          r_mdc;
  logic          r_mdo;
  logic          r_oe;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic [31:0]   w_frame;
  logic [31:0]   w_tx_shift;
  logic          w_mdio_s;
  logic          w_idle;

  // Everything after the preamble, MSB first; read TA/DATA slots are driven high but not enabled.
  assign w_frame    = {2'b01, (req_write ? 2'b01 : 2'b10), PHY_ADDR, req_reg,
                       (req_write ? 2'b10 : 2'b11), (req_write ? req_wdata : 16'hFFFF)};
  assign w_tx_shift = {r_tx[30:0], 1'b1};
  assign w_mdio_s   = r_sync[1];
  assign w_idle     = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], mdio_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_tx        <= '1;
      r_rx        <= '0;
      r_write     <= 1'b0;
      r_ta_err    <= 1'b0;
      r_mdc       <= 1'b0;
      r_mdo       <= 1'b1;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_rx     <= '0;
            r_ta_err <= 1'b0;
            r_cnt    <= '0;
            r_mdc    <= 1'b0;
            r_oe     <= 1'b1;
            if (PREAMBLE_EN) begin
              r_state <= S_PREAMBLE;
              r_bits  <= 5'd31;
              r_mdo   <= 1'b1;
              r_tx    <= w_frame;
            end else begin
              r_state <= S_HEADER;
              r_bits  <= 5'd13;
              r_mdo   <= w_frame[31];
              r_tx    <= {w_frame[30:0], 1'b1};
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          // Sample on the last low-phase cycle, i.e. just before the rising MDC edge.
          if (r_cnt == LAST_LOW) begin
            r_mdc <= 1'b1;
            if (r_state == S_TA && r_bits == 5'd0) r_ta_err <= w_mdio_s;
            if (r_state == S_DATA) r_rx <= {r_rx[14:0], w_mdio_s};
          end
          if (r_cnt == LAST_HIGH) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
            if (r_bits != 5'd0) begin
              r_bits <= r_bits - 5'd1;
              if (r_state != S_PREAMBLE) begin
                r_mdo <= r_tx[31];
                r_tx  <= w_tx_shift;
              end
            end else begin
              case (r_state)
                S_PREAMBLE: begin
                  r_state <= S_HEADER;
                  r_bits  <= 5'd13;
                  r_mdo   <= r_tx[31];
                  r_tx    <= w_tx_shift;
                end
                S_HEADER: begin
                  r_state <= S_TA;
                  r_bits  <= 5'd1;
                  r_mdo   <= r_tx[31];
                  r_tx    <= w_tx_shift;
                  r_oe    <= r_write;
                end
                S_TA: begin
                  r_state <= S_DATA;
                  r_bits  <= 5'd15;
                  r_mdo   <= r_tx[31];
                  r_tx    <= w_tx_shift;
                end
                default: begin
                  r_state     <= S_DONE;
                  r_mdo       <= 1'b1;
                  r_oe        <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_write ? 16'h0000 : r_rx;
                  r_rsp_err   <= ~r_write & r_ta_err;
                end
              endcase
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready = w_idle;
  assign busy      = ~w_idle;
  assign mdc       = r_mdc;
  assign mdio_o    = r_mdo;
  assign mdio_oe   = r_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
